mul_ctrl: RTL and testbench

- Sequencing controller between the ALU issue stage and the 32-cycle radix-2 `booth` multiplier.
- Accepts RV32M multiply ops (MUL, MULH, MULHSU, MULHU) over a valid/ready handshake.
- Maps operands and signedness onto the `booth` ports, pulses `start`, and captures the one-cycle product.
- Applies the unsigned-rs1 high-word correction, selects the result word and returns it with its tag over a valid/ready response channel. Supports flush of in-flight work.

---
 rtl/core_config_pkg.sv | 47 ++++
 rtl/mul_ctrl_if.sv | 38 +++
 rtl/mul_result_fix.sv | 38 +++
 rtl/mul_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mul_ctrl.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the multiply path.
//
// Contents:
//   XLEN               operand width (only 32 is supported by mul_ctrl)
//   mul_op_t           RV32M multiply operation encoding
//   mul_cls_t          signedness class of a computed 64-bit product
//   mul_ctrl_state_t   mul_ctrl sequencing states
//   mul_op_class()     signedness class produced by the booth for a given op
package core_config_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MulOpMul    = 2'b00,
    MulOpMulh   = 2'b01,
    MulOpMulhsu = 2'b10,
    MulOpMulhu  = 2'b11
  } mul_op_t;

  // SS: rs1 signed, rs2 signed; SU: rs1 signed, rs2 unsigned; UU: both unsigned.
  typedef enum logic [1:0] {
    MulClsSs = 2'b00,
    MulClsSu = 2'b01,
    MulClsUu = 2'b10
  } mul_cls_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } mul_ctrl_state_t;

  // MUL runs the booth with X signed, Y unsigned and no high-word correction,
  // so its full 64-bit product is exactly the SU product.
  function automatic mul_cls_t mul_op_class(input mul_op_t op);
    mul_cls_t cls;
    case (op)
      MulOpMulh:   cls = MulClsSs;
      MulOpMulhu:  cls = MulClsUu;
      default:     cls = MulClsSu;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/response channel between the ALU issue stage and mul_ctrl.
//
// Signals:
//   req_valid/req_ready   request handshake (issue -> controller)
//   req_op/rs1/rs2/tag    request payload
//   rsp_valid/rsp_ready   response handshake (controller -> issue)
//   rsp_data/rsp_tag      response payload
// Modports: master = issue side, slave = mul_ctrl.
interface mul_ctrl_if
  import core_config_pkg::*;
#(
  parameter int unsigned XLEN  = core_config_pkg::XLEN,
  parameter int unsigned TAG_W = 5
);

  logic             req_valid;
  logic             req_ready;
  mul_op_t          req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );

endinterface

// File: rtl/mul_result_fix.sv
// Combinational high-word correction for the booth product.
//
// The booth always recodes X as two's complement. When rs1 is meant to be
// unsigned (MULHU) and its MSB is set, the booth has effectively multiplied
// by (rs1 - 2^XLEN), so rs2 is added back into the high word. The low word is
// never affected.
//
// Ports:
//   mul_z_i      raw booth product
//   rs2_i        multiplier operand
//   op_i         operation of the product
//   rs1_msb_i    rs1[XLEN-1]
//   prod_o       corrected 64-bit product
module mul_result_fix
  import core_config_pkg::*;
#(
  parameter int unsigned XLEN = core_config_pkg::XLEN
) (
  input  logic [2*XLEN-1:0] mul_z_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  mul_op_t           op_i,
  input  logic              rs1_msb_i,
  output logic [2*XLEN-1:0] prod_o
);

  logic            fix_en;
  logic [XLEN-1:0] hi_word;

  always_comb begin
    fix_en  = (op_i == MulOpMulhu) && rs1_msb_i;
    hi_word = mul_z_i[2*XLEN-1:XLEN];
    if (fix_en) begin
      hi_word = hi_word + rs2_i;
    end
    prod_o = {hi_word, mul_z_i[XLEN-1:0]};
  end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencing controller between the ALU issue stage and the 32-cycle radix-2
// booth multiplier.
//
// Accepts one RV32M multiply at a time, drives the booth operands and a
// one-cycle start pulse, captures the booth product, applies the MULHU
// high-word correction and returns the selected word with its tag.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (shared with booth)
//   bus               mul_ctrl_if.slave request/response channel
//   flush_i           discard the accepted/in-flight op
//   mul_start_o       booth start pulse
//   mul_x_signed_o    booth X signedness (informational, booth recodes X signed)
//   mul_y_signed_o    booth Y signedness
//   mul_x_o, mul_y_o  booth operands, stable from start until the next accept
//   mul_valid_i       booth result pulse
//   mul_z_i           booth product, meaningful only with mul_valid_i
//   busy_o            controller not idle
//
// Build option: define MUL_RESULT_REUSE_EN to keep the last completed product
// and answer a matching request without running the booth.
module mul_ctrl
  import core_config_pkg::*;
#(
  parameter int unsigned XLEN  = core_config_pkg::XLEN,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_ctrl_if.slave         bus,
  input  logic              flush_i,
  output logic              mul_start_o,
  output logic              mul_x_signed_o,
  output logic              mul_y_signed_o,
  output logic [XLEN-1:0]   mul_x_o,
  output logic [XLEN-1:0]   mul_y_o,
  input  logic              mul_valid_i,
  input  logic [2*XLEN-1:0] mul_z_i,
  output logic              busy_o
);

  mul_ctrl_state_t  state_q;
  mul_op_t          op_q;
  logic [XLEN-1:0]  rs1_q;
  logic [XLEN-1:0]  rs2_q;
  logic [TAG_W-1:0] tag_q;
  logic             mul_start_q;
  logic             mul_x_signed_q;
  logic             mul_y_signed_q;
  logic             rsp_valid_q;
  logic [XLEN-1:0]  rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic              accept;
  logic [2*XLEN-1:0] fixed_prod;
  logic [XLEN-1:0]   result_word;
  logic              cache_hit;
  logic [XLEN-1:0]   cache_word;

  assign accept = bus.req_valid && (state_q == StIdle) && !flush_i;

  // Shared by the capture path and the cache fill.
  mul_result_fix #(
    .XLEN (XLEN)
  ) u_result_fix (
    .mul_z_i   (mul_z_i),
    .rs2_i     (rs2_q),
    .op_i      (op_q),
    .rs1_msb_i (rs1_q[XLEN-1]),
    .prod_o    (fixed_prod)
  );

  assign result_word = (op_q == MulOpMul) ? fixed_prod[XLEN-1:0]
                                          : fixed_prod[2*XLEN-1:XLEN];

`ifdef MUL_RESULT_REUSE_EN
  logic              cache_valid_q;
  logic [XLEN-1:0]   cache_rs1_q;
  logic [XLEN-1:0]   cache_rs2_q;
  mul_cls_t          cache_cls_q;
  logic [2*XLEN-1:0] cache_prod_q;
  logic              cache_fill;

  // Only non-flushed completions fill; the cache is never speculative, so a
  // later flush leaves it intact.
  assign cache_fill = (state_q == StWait) && mul_valid_i && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_cls_q   <= MulClsSs;
      cache_prod_q  <= '0;
    end else if (cache_fill) begin
      cache_valid_q <= 1'b1;
      cache_rs1_q   <= rs1_q;
      cache_rs2_q   <= rs2_q;
      cache_cls_q   <= mul_op_class(op_q);
      cache_prod_q  <= fixed_prod;
    end
  end

  // The low word is identical for every class, so MUL hits on operands alone.
  assign cache_hit = cache_valid_q
                  && (cache_rs1_q == bus.req_rs1)
                  && (cache_rs2_q == bus.req_rs2)
                  && ((bus.req_op == MulOpMul) || (cache_cls_q == mul_op_class(bus.req_op)));
  assign cache_word = (bus.req_op == MulOpMul) ? cache_prod_q[XLEN-1:0]
                                               : cache_prod_q[2*XLEN-1:XLEN];
`else
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      op_q           <= MulOpMul;
      rs1_q          <= '0;
      rs2_q          <= '0;
      tag_q          <= '0;
      mul_start_q    <= 1'b0;
      mul_x_signed_q <= 1'b0;
      mul_y_signed_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_tag_q      <= '0;
    end else begin
      mul_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q           <= bus.req_op;
            rs1_q          <= bus.req_rs1;
            rs2_q          <= bus.req_rs2;
            tag_q          <= bus.req_tag;
            mul_x_signed_q <= (bus.req_op == MulOpMulh) || (bus.req_op == MulOpMulhsu);
            mul_y_signed_q <= (bus.req_op == MulOpMulh);
            if (cache_hit) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= cache_word;
              rsp_tag_q   <= bus.req_tag;
              state_q     <= StDone;
            end else begin
              mul_start_q <= 1'b1;
              state_q     <= StStart;
            end
          end
        end
        StStart: begin
          // The start pulse has already reached the booth; a flush must drain it.
          state_q <= flush_i ? StDrain : StWait;
        end
        StWait: begin
          if (flush_i) begin
            // A product arriving alongside the flush is the one being drained.
            state_q <= mul_valid_i ? StIdle : StDrain;
          end else if (mul_valid_i) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= result_word;
            rsp_tag_q   <= tag_q;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Handshake and flush both retire the response; no accept this cycle.
          if (bus.rsp_ready || flush_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StDrain: begin
          if (mul_valid_i) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign mul_start_o    = mul_start_q;
  assign mul_x_signed_o = mul_x_signed_q;
  assign mul_y_signed_o = mul_y_signed_q;
  assign mul_x_o        = rs1_q;
  assign mul_y_o        = rs2_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural booth and a reference
// model that computes RV32M results directly from the operand signedness.
module tb_mul_ctrl;
  import core_config_pkg::*;

  localparam int unsigned TagW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush;
  logic            mul_start;
  logic            mul_x_signed;
  logic            mul_y_signed;
  logic [31:0]     mul_x;
  logic [31:0]     mul_y;
  logic            mul_valid;
  logic [63:0]     mul_z;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int start_overlap = 0;

  mul_ctrl_if #(.XLEN(32), .TAG_W(TagW)) bus ();

  mul_ctrl #(.XLEN(32), .TAG_W(TagW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush_i        (flush),
    .mul_start_o    (mul_start),
    .mul_x_signed_o (mul_x_signed),
    .mul_y_signed_o (mul_y_signed),
    .mul_x_o        (mul_x),
    .mul_y_o        (mul_y),
    .mul_valid_i    (mul_valid),
    .mul_z_i        (mul_z),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Booth: X always two's complement, Y per Y_signed; valid 33 cycles after start.
  function automatic logic [63:0] booth_product(input logic [31:0] x, input logic [31:0] y,
                                                input logic ys);
    logic [63:0] ex, ey;
    ex = {{32{x[31]}}, x};
    ey = ys ? {{32{y[31]}}, y} : {32'h0, y};
    return ex * ey;
  endfunction

  int unsigned booth_cnt;
  logic [31:0] bx, by;
  logic        bys;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      booth_cnt <= 0;
      mul_valid <= 1'b0;
      mul_z     <= '0;
      bx        <= '0;
      by        <= '0;
      bys       <= 1'b0;
    end else begin
      mul_valid <= 1'b0;
      mul_z     <= {$urandom, $urandom};
      if (mul_start) begin
        if (booth_cnt != 0) start_overlap <= start_overlap + 1;
        booth_cnt <= 32;
        bx        <= mul_x;
        by        <= mul_y;
        bys       <= mul_y_signed;
      end else if (booth_cnt == 1) begin
        booth_cnt <= 0;
        mul_valid <= 1'b1;
        mul_z     <= booth_product(bx, by, bys);
      end else if (booth_cnt > 1) begin
        booth_cnt <= booth_cnt - 1;
      end
    end
  end

  // Architectural RV32M result.
  function automatic logic [31:0] ref_result(input mul_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, za, sb, zb, p;
    sa = {{32{a[31]}}, a};
    za = {32'h0, a};
    sb = {{32{b[31]}}, b};
    zb = {32'h0, b};
    case (op)
      MulOpMulh:   p = sa * sb;
      MulOpMulhsu: p = sa * zb;
      default:     p = za * zb;
    endcase
    return (op == MulOpMul) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [5];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Driver: issue one op with rsp_ready high; lat counts clock edges from the
  // accept edge to the first cycle showing rsp_valid (100 = timed out).
  task automatic do_op(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TagW-1:0] tag, output logic [31:0] data,
                       output logic [TagW-1:0] rtag, output int lat, output int starts);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = tag;
    bus.rsp_ready = 1'b1;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat    = 0;
    starts = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      if (mul_start === 1'b1) starts++;
      @(negedge clk);
      lat++;
    end
    data = bus.rsp_data;
    rtag = bus.rsp_tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (mul_start !== 1'b0) begin errors++;
      $display("FAIL reset_mul_start: got %b want 0", mul_start); end
    checks++; if (bus.rsp_data !== 32'h0 || bus.rsp_tag !== '0) begin errors++;
      $display("FAIL reset_rsp_payload: got %h/%h want 0/0", bus.rsp_data, bus.rsp_tag); end
    checks++; if (mul_x !== 32'h0 || mul_y !== 32'h0) begin errors++;
      $display("FAIL reset_operands: got %h/%h want 0/0", mul_x, mul_y); end
    checks++; if (mul_x_signed !== 1'b0 || mul_y_signed !== 1'b0) begin errors++;
      $display("FAIL reset_signs: got %b%b want 00", mul_x_signed, mul_y_signed); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++;
      $display("FAIL idle_req_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_directed();
    mul_op_t     ops  [4];
    logic [31:0] as   [4];
    logic [31:0] bs   [4];
    logic [31:0] exps [4];
    logic [31:0] data;
    logic [TagW-1:0] rtag;
    int lat, starts;
    ops  = '{MulOpMul, MulOpMulhu, MulOpMulh, MulOpMulhsu};
    as   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bs   = '{32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], TagW'(i + 9), data, rtag, lat, starts);
      checks++; if (data !== exps[i]) begin errors++;
        $display("FAIL directed_data[%0d]: got %h want %h", i, data, exps[i]); end
      checks++; if (rtag !== TagW'(i + 9)) begin errors++;
        $display("FAIL directed_tag[%0d]: got %h want %h", i, rtag, TagW'(i + 9)); end
      checks++; if (lat != 34) begin errors++;
        $display("FAIL directed_latency[%0d]: got %0d want 34", i, lat); end
      checks++; if (starts != 1) begin errors++;
        $display("FAIL directed_start_cycles[%0d]: got %0d want 1", i, starts); end
      checks++; if (mul_x !== as[i] || mul_y !== bs[i]) begin errors++;
        $display("FAIL directed_operands[%0d]: got %h/%h want %h/%h", i, mul_x, mul_y,
                 as[i], bs[i]); end
      checks++;
      if (mul_y_signed !== (ops[i] == MulOpMulh) ||
          mul_x_signed !== (ops[i] == MulOpMulh || ops[i] == MulOpMulhsu)) begin
        errors++;
        $display("FAIL directed_signs[%0d]: got x=%b y=%b for op %0d", i, mul_x_signed,
                 mul_y_signed, ops[i]);
      end
    end
  endtask

  task automatic test_random();
    mul_op_t op;
    logic [31:0] a, b, data, exp;
    logic [TagW-1:0] tag, rtag;
    int lat, starts;
    for (int i = 0; i < 24; i++) begin
      op  = mul_op_t'($urandom_range(0, 3));
      a   = rand_operand();
      b   = rand_operand();
      tag = TagW'($urandom);
      exp = ref_result(op, a, b);
      do_op(op, a, b, tag, data, rtag, lat, starts);
      checks++; if (data !== exp || rtag !== tag) begin errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h/%h want %h/%h", i, op, a, b,
                 data, rtag, exp, tag); end
      checks++; if (lat != 34) begin errors++;
        $display("FAIL random_latency[%0d]: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = MulOpMulh;
    bus.req_rs1   = 32'h8000_0000;
    bus.req_rs2   = 32'h8000_0000;
    bus.req_tag   = 5'h13;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 34) begin errors++;
      $display("FAIL bp_latency: got %0d want 34", lat); end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h4000_0000 || bus.rsp_tag !== 5'h13 ||
          bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h t=%h rdy=%b want 1/40000000/13/0", c,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_release: got v=%b busy=%b want 0/0", bus.rsp_valid, busy); end
  endtask

  task automatic test_flush();
    int lat, starts, seen_rsp, guard;
    logic [31:0] a, b, data, exp;
    logic [TagW-1:0] rtag;
    // Flush from WAIT and from START: both must drain the booth before idling.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = MulOpMul;
      bus.req_rs1   = 32'h1234_5678;
      bus.req_rs2   = 32'h9;
      bus.req_tag   = 5'h07;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 0;
      seen_rsp = 0;
      if (k == 0) begin
        repeat (4) @(negedge clk);
        lat = 4;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      lat++;
      while (busy === 1'b1 && lat < 100) begin
        if (bus.rsp_valid === 1'b1) seen_rsp++;
        @(negedge clk);
        lat++;
      end
      checks++; if (seen_rsp != 0) begin errors++;
        $display("FAIL flush_no_rsp[%0d]: got %0d rsp cycles want 0", k, seen_rsp); end
      checks++; if (lat != 34) begin errors++;
        $display("FAIL flush_drain_len[%0d]: got %0d want 34", k, lat); end
      a   = $urandom;
      b   = $urandom;
      exp = ref_result(MulOpMulhu, a, b);
      do_op(MulOpMulhu, a, b, TagW'(5'h1A + k), data, rtag, lat, starts);
      checks++; if (data !== exp || rtag !== TagW'(5'h1A + k) || lat != 34) begin errors++;
        $display("FAIL flush_next_op[%0d]: got %h/%h lat %0d want %h/%h lat 34", k, data, rtag,
                 lat, exp, TagW'(5'h1A + k)); end
    end

    // Flush in DONE drops the response.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = MulOpMulh;
    bus.req_rs1   = 32'h0000_0100;
    bus.req_rs2   = 32'h0000_0200;
    bus.req_tag   = 5'h05;
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard = 0;
    while (bus.rsp_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++;
      $display("FAIL flush_done_setup: got rsp_valid %b want 1", bus.rsp_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL flush_done: got v=%b busy=%b want 0/0", bus.rsp_valid, busy); end

    // Flush in IDLE blocks acceptance for that cycle only.
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = MulOpMul;
    bus.req_rs1   = 32'h0001_0003;
    bus.req_rs2   = 32'h0000_0005;
    bus.req_tag   = 5'h11;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL flush_idle_block: got busy %b want 0", busy); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL flush_idle_accept_after: got busy %b want 1", busy); end
    guard = 0;
    while (bus.rsp_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (bus.rsp_data !== 32'h0005_000F || bus.rsp_tag !== 5'h11) begin errors++;
      $display("FAIL flush_idle_result: got %h/%h want 0005000f/11", bus.rsp_data,
               bus.rsp_tag); end
    @(negedge clk);
    checks++; if (start_overlap != 0) begin errors++;
      $display("FAIL start_during_booth: got %0d want 0", start_overlap); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] data;
    logic [TagW-1:0] rtag;
    int lat, starts;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = MulOpMulh;
    bus.req_rs1   = 32'hDEAD_BEEF;
    bus.req_rs2   = 32'h1234_5678;
    bus.req_tag   = 5'h1F;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_ctrl: got busy=%b v=%b start=%b want 0/0/0", busy,
               bus.rsp_valid, mul_start); end
    checks++; if (bus.rsp_data !== 32'h0 || bus.rsp_tag !== '0) begin errors++;
      $display("FAIL rst_async_rsp: got %h/%h want 0/0", bus.rsp_data, bus.rsp_tag); end
    checks++; if (mul_x !== 32'h0 || mul_y !== 32'h0 || mul_x_signed !== 1'b0 ||
                  mul_y_signed !== 1'b0) begin errors++;
      $display("FAIL rst_async_booth: got %h/%h %b%b want 0/0 00", mul_x, mul_y,
               mul_x_signed, mul_y_signed); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(MulOpMul, 32'd7, 32'd6, 5'h03, data, rtag, lat, starts);
    checks++; if (data !== 32'd42 || rtag !== 5'h03 || lat != 34) begin errors++;
      $display("FAIL rst_fresh_op: got %0d/%h lat %0d want 42/03 lat 34", data, rtag, lat); end
  endtask

  task automatic test_back_to_back();
    mul_op_t     ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp_q [$];
    logic [TagW-1:0] tag_q [$];
    int issued, got, cyc;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      ops[i] = mul_op_t'($urandom_range(0, 3));
      as[i]  = rand_operand();
      bs[i]  = rand_operand();
      exp_q.push_back(ref_result(ops[i], as[i], bs[i]));
      tag_q.push_back(TagW'(i + 20));
    end
    issued = 0;
    got = 0;
    cyc = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = ops[0];
    bus.req_rs1   = as[0];
    bus.req_rs2   = bs[0];
    bus.req_tag   = TagW'(20);
    while (got < 4 && cyc < 400) begin
      if (bus.rsp_valid === 1'b1) begin
        checks++; if (bus.rsp_data !== exp_q[got] || bus.rsp_tag !== tag_q[got]) begin
          errors++;
          $display("FAIL b2b[%0d]: got %h/%h want %h/%h", got, bus.rsp_data, bus.rsp_tag,
                   exp_q[got], tag_q[got]); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++;
          $display("FAIL b2b_ready_in_rsp[%0d]: got %b want 0", got, bus.req_ready); end
        got++;
      end
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        issued++;
        if (issued < 4) begin
          bus.req_op  = ops[issued];
          bus.req_rs1 = as[issued];
          bus.req_rs2 = bs[issued];
          bus.req_tag = TagW'(20 + issued);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (got != 4) begin errors++;
      $display("FAIL b2b_count: got %0d want 4", got); end
  endtask

`ifdef MUL_RESULT_REUSE_EN
  task automatic test_reuse();
    logic [31:0] a, b, data;
    logic [TagW-1:0] rtag;
    int lat, starts;
    a = $urandom | 32'h8000_0000;
    b = $urandom;
    do_op(MulOpMulhu, a, b, 5'h01, data, rtag, lat, starts);
    checks++; if (data !== ref_result(MulOpMulhu, a, b) || lat != 34) begin errors++;
      $display("FAIL reuse_fill: got %h lat %0d want %h lat 34", data, lat,
               ref_result(MulOpMulhu, a, b)); end
    // A hit shows rsp_valid in the cycle right after the accept cycle.
    do_op(MulOpMul, a, b, 5'h02, data, rtag, lat, starts);
    checks++; if (data !== ref_result(MulOpMul, a, b) || rtag !== 5'h02 || lat != 0 ||
                  starts != 0) begin errors++;
      $display("FAIL reuse_hit: got %h/%h lat %0d starts %0d want %h/02 lat 0 starts 0", data,
               rtag, lat, starts, ref_result(MulOpMul, a, b)); end
    do_op(MulOpMulh, a, b, 5'h04, data, rtag, lat, starts);
    checks++; if (data !== ref_result(MulOpMulh, a, b) || lat != 34) begin errors++;
      $display("FAIL reuse_class_miss: got %h lat %0d want %h lat 34", data, lat,
               ref_result(MulOpMulh, a, b)); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = MulOpMul;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef MUL_RESULT_REUSE_EN
    test_reuse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
